// File: rtl/regfile_sb_pp.sv
// Pipeline register file with two asynchronous read ports, one write-back port
// and a per-register busy scoreboard used by decode to stall on RAW hazards.
module regfile_sb_pp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] Rs,
  output logic [DATA_W-1:0] Rt,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [CW-1:0]     cnt;

  logic set, clr, inc, dec;
  logic [CW-1:0] cnt_next;

  assign set = iss_valid && !((ZERO_REG != 0) && (iss_rd == '0));
  assign clr = RegWrite  && !((ZERO_REG != 0) && (rd == '0));

  // A clear on the register being set this cycle is superseded, so it never decrements.
  always_comb begin
    inc      = set && !busy[iss_rd];
    dec      = clr && busy[rd] && !(set && (iss_rd == rd));
    cnt_next = cnt;
    if (inc) cnt_next = cnt_next + CW'(1);
    if (dec) cnt_next = cnt_next - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (clr) regs[rd] <= Data_In;
      if (clr) busy[rd] <= 1'b0;
      if (set) busy[iss_rd] <= 1'b1;
      cnt <= cnt_next;
    end
  end

  always_comb begin
    Rs      = regs[rs];
    rs_busy = busy[rs];
    if ((BYPASS != 0) && RegWrite && (rd == rs)) begin
      Rs      = Data_In;
      rs_busy = 1'b0;
    end
    if ((ZERO_REG != 0) && (rs == '0)) begin
      Rs      = '0;
      rs_busy = 1'b0;
    end
    if (rst) begin
      Rs      = '0;
      rs_busy = 1'b0;
    end
  end

  always_comb begin
    Rt      = regs[rt];
    rt_busy = busy[rt];
    if ((BYPASS != 0) && RegWrite && (rd == rt)) begin
      Rt      = Data_In;
      rt_busy = 1'b0;
    end
    if ((ZERO_REG != 0) && (rt == '0)) begin
      Rt      = '0;
      rt_busy = 1'b0;
    end
    if (rst) begin
      Rt      = '0;
      rt_busy = 1'b0;
    end
  end

  assign busy_cnt = rst ? '0 : cnt;

endmodule

// File: tb/tb_regfile_sb_pp.sv
// Directed self-checking bench for regfile_sb_pp with default parameters.
module tb_regfile_sb_pp;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs, rt, rd, iss_rd;
  logic [31:0] Rs, Rt, Data_In;
  logic        rs_busy, rt_busy, RegWrite, iss_valid;
  logic [5:0]  busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  regfile_sb_pp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .Rs(Rs), .Rt(Rt),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .RegWrite(RegWrite), .rd(rd),
    .Data_In(Data_In), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_rs, input logic [31:0] e_rt,
                           input logic e_sb, input logic e_tb, input logic [5:0] e_cnt);
    check({tag, ".Rs"}, Rs, e_rs);
    check({tag, ".Rt"}, Rt, e_rt);
    check({tag, ".rs_busy"}, 32'(rs_busy), 32'(e_sb));
    check({tag, ".rt_busy"}, 32'(rt_busy), 32'(e_tb));
    check({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(e_cnt));
  endtask

  initial begin
    rst = 1'b1; rs = '0; rt = '0; rd = '0; iss_rd = '0;
    Data_In = '0; RegWrite = 1'b0; iss_valid = 1'b0;
    @(negedge clk); #1;
    check_all("in_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk); rst = 1'b0;

    // Every register reads zero and idle after reset.
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i); #1;
      check_all("post_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    end

    // Write-through bypass, then committed value.
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd7; Data_In = 32'hDEADBEEF; rs = 5'd7; rt = 5'd6; #1;
    check_all("bypass_same_cycle", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk); RegWrite = 1'b0; rt = 5'd7; #1;
    check_all("after_write", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);

    // Register 0 ignores writes and issues.
    @(negedge clk);
    RegWrite = 1'b1; rd = 5'd0; Data_In = 32'h5; iss_valid = 1'b1; iss_rd = 5'd0;
    rs = 5'd0; rt = 5'd0; #1;
    check_all("zero_same_cycle", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    @(negedge clk); RegWrite = 1'b0; iss_valid = 1'b0; #1;
    check_all("zero_after", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);

    // Issue 3 then 9.
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk); iss_rd = 5'd9; rs = 5'd3; #1;
    check("busy_visible_next_cycle", 32'(rs_busy), 32'd1);
    check("cnt_one", 32'(busy_cnt), 32'd1);
    @(negedge clk); iss_valid = 1'b0; rs = 5'd3; rt = 5'd9; #1;
    check_all("two_busy", 32'h0, 32'h0, 1'b1, 1'b1, 6'd2);

    // Write-back 3 masks busy and forwards in the same cycle.
    RegWrite = 1'b1; rd = 5'd3; Data_In = 32'h11; #1;
    check_all("wb3_same_cycle", 32'h11, 32'h0, 1'b0, 1'b1, 6'd2);
    @(negedge clk); RegWrite = 1'b0; #1;
    check_all("wb3_after", 32'h11, 32'h0, 1'b0, 1'b1, 6'd1);

    // Issue 4, then issue and write-back 4 together: stays busy, count unchanged.
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd4;
    @(negedge clk); RegWrite = 1'b1; rd = 5'd4; Data_In = 32'h44; rs = 5'd4; #1;
    check("cnt_before_same_idx", 32'(busy_cnt), 32'd2);
    check("same_idx_masked", 32'(rs_busy), 32'd0);
    @(negedge clk); RegWrite = 1'b0; iss_valid = 1'b0; #1;
    check_all("same_idx_after", 32'h44, 32'h0, 1'b1, 1'b1, 6'd2);

    // Issue 5 while writing back 4.
    iss_valid = 1'b1; iss_rd = 5'd5; RegWrite = 1'b1; rd = 5'd4; Data_In = 32'h55; rt = 5'd5;
    @(negedge clk); iss_valid = 1'b0; RegWrite = 1'b0; #1;
    check_all("diff_idx_after", 32'h55, 32'h0, 1'b0, 1'b1, 6'd2);

    // Clearing a non-busy register is a no-op on the count.
    RegWrite = 1'b1; rd = 5'd12; Data_In = 32'hC;
    @(negedge clk); RegWrite = 1'b0; rs = 5'd12; rt = 5'd9; #1;
    check_all("clear_idle", 32'hC, 32'h0, 1'b0, 1'b1, 6'd2);

    // Reach three busy, then reset between edges.
    iss_valid = 1'b1; iss_rd = 5'd6;
    @(negedge clk); iss_valid = 1'b0; rs = 5'd7; rt = 5'd6; #1;
    check_all("three_busy", 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 6'd3);
    @(posedge clk); #2; rst = 1'b1; #1;
    check_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    RegWrite = 1'b1; rd = 5'd8; Data_In = 32'hAB; iss_valid = 1'b1; iss_rd = 5'd8;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; RegWrite = 1'b0; iss_valid = 1'b0; rs = 5'd7; rt = 5'd8; #1;
    check_all("after_reset", 32'h0, 32'h0, 1'b0, 1'b0, 6'd0);
    rt = 5'd9; #1;
    check("after_reset_busy9", 32'(rt_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
